instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Program-counter and instruction-register stage for the multi-cycle LEGv8 datapath. It holds PC, the fetched instruction word, and the address of that instruction. Each cycle it consumes the PS, PCsel and IL fields of the control word, together with the generated constant, and drives `I[31:0]` into the control unit. It also supplies the link value for BL, a sticky misaligned-target flag, and a retired-fetch counter.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `COUNT_W`, default 32: width of the fetch counter.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `PS` in 2: PC function. 00 hold, 01 increment, 10 jump to register, 11 PC-relative branch.
- `PCsel` in 1: offset source for PS=11. 1 = `constant`, 0 = `A_bus`.
- `IL` in 1: instruction load enable.
- `constant` in 64: signed word offset from the constant generator.
- `A_bus` in 64: register-file port A data.
- `mem_data` in 32: instruction memory read data. Combinational read at address `PC`.
- `PC` out 64: current program counter, which is the fetch address.
- `I` out 32: instruction register.
- `IPC` out 64: address of the instruction currently held in `I`.
- `PC4` out 64: `IPC + 4`, combinational. This is the link value for BL/BLR.
- `fault` out 1: sticky flag for a misaligned register target.
- `fetch_count` out COUNT_W: number of instructions loaded.

## Operation
- Registers: `PC`, `I`, `IPC`, `fault`, `fetch_count`. All update only on the rising edge of `clock`.
- PC next-state, evaluated from pre-edge values:
  - PS=00: `PC` unchanged.
  - PS=01: `PC + 4`.
  - PS=10: `{A_bus[63:2], 2'b00}`.
  - PS=11: `IPC + (offset << 2)`, where offset is `constant` if PCsel=1 and `A_bus` if PCsel=0.
- Arithmetic is 64-bit two's complement, modulo 2^64. Wrap-around above 64'hFFFF_FFFF_FFFF_FFFC goes to 0 with no flag.
- Branches are relative to `IPC`, not `PC`. At execute time `PC` has already advanced past the branch, so `IPC` is the correct base.
- IL=1:
  - `I <= mem_data`.
  - `IPC <= PC`, using the pre-edge PC.
  - `fetch_count` increments and saturates at all-ones.
- IL=0: `I`, `IPC` and `fetch_count` hold.
- `fault` is set when PS=10 and `A_bus[1:0] != 0`. It stays set until reset. The jump still occurs, to the word-aligned address.
- Simultaneous IL=1 and PS≠01 is legal. The PC update uses the old `IPC`, and `IPC` takes the old `PC`.
- Reset:
  - `PC = RESET_PC`, `I = 0`, `IPC = RESET_PC`, `fault = 0`, `fetch_count = 0`.
  - Reset overrides every other input in the same cycle.
  - Asserting reset mid-instruction discards the in-flight instruction.

## Timing
- Latency is one cycle for every register. `PC`, `I`, `IPC`, `fault` and `fetch_count` are valid immediately after the clock edge.
- `PC4` is combinational from `IPC` and has no register stage.
- The fetch cycle (IL=1, PS=01) captures `mem_data` at the pre-edge PC and advances PC by 4 on the same edge.
- The next cycle's control word is decoded from the new `I`.
- No handshake: `mem_data` must be valid within the same cycle that `PC` is stable.

## Test plan
- Reset with `RESET_PC` = 64'h100, then IL=1 and PS=01 for 3 cycles with mem_data 32'hAAAA0001, 0002, 0003.
  - Expect PC 104/108/10C.
  - Expect IPC 100/104/108.
  - Expect final I = 32'hAAAA0003 and fetch_count = 3.
- Fetch at PC = 64'h200, then PS=11, PCsel=1, constant = -2.
  - Expect PC = 64'h1F8, i.e. IPC 200 − 8.
  - Expect PC4 = 64'h204 before the branch edge.
- PS=10 with A_bus = 64'h403.
  - Expect PC = 64'h400 and fault = 1.
  - Expect fault to remain 1 after a following legal PS=10 with A_bus = 64'h500.
  - Expect fault to clear only on reset.
- PS=00 for 5 cycles with IL=0.
  - Expect PC, I, IPC and fetch_count all unchanged.
- Set PC to 64'hFFFF_FFFF_FFFF_FFFC via PS=10, then apply PS=01.
  - Expect PC = 0 and fault = 0.
- Assert reset in the same cycle as IL=1 and PS=11.
  - Expect PC = RESET_PC, I = 0 and fetch_count = 0.
- With COUNT_W=2, perform 5 fetches.
  - Expect fetch_count = 3, saturated.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Program counter and instruction register stage for the multi-cycle LEGv8 datapath.
// Holds PC, the fetched instruction and its address, a sticky misaligned-jump flag and a fetch counter.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         PS,
    input  logic               PCsel,
    input  logic               IL,
    input  logic [63:0]        constant,
    input  logic [63:0]        A_bus,
    input  logic [31:0]        mem_data,
    output logic [63:0]        PC,
    output logic [31:0]        I,
    output logic [63:0]        IPC,
    output logic [63:0]        PC4,
    output logic               fault,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    logic [63:0] offset;
    logic [63:0] next_pc;
    logic        misaligned;

    // Branches are taken relative to the address of the executing instruction.
    always_comb begin
        offset     = PCsel ? constant : A_bus;
        misaligned = (PS == PS_JUMP) && (A_bus[1:0] != 2'b00);
        next_pc    = PC;
        case (PS)
            PS_HOLD:   next_pc = PC;
            PS_INC:    next_pc = PC + 64'd4;
            PS_JUMP:   next_pc = {A_bus[63:2], 2'b00};
            PS_BRANCH: next_pc = IPC + {offset[61:0], 2'b00};
            default:   next_pc = PC;
        endcase
    end

    assign PC4 = IPC + 64'd4;

    always_ff @(posedge clock) begin
        if (reset) begin
            PC          <= RESET_PC;
            I           <= 32'h0;
            IPC         <= RESET_PC;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            PC <= next_pc;
            if (misaligned) begin
                fault <= 1'b1;
            end
            if (IL) begin
                I   <= mem_data;
                IPC <= PC;
                if (fetch_count != {COUNT_W{1'b1}}) begin
                    fetch_count <= fetch_count + COUNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit, plus a saturation check on a narrow-counter instance.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  PS;
    logic        PCsel;
    logic        IL;
    logic [63:0] constant;
    logic [63:0] A_bus;
    logic [31:0] mem_data;

    logic [63:0] PC, IPC, PC4;
    logic [31:0] I;
    logic        fault;
    logic [31:0] fetch_count;

    logic [63:0] PC_n, IPC_n, PC4_n;
    logic [31:0] I_n;
    logic        fault_n;
    logic [1:0]  fetch_count_n;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.RESET_PC(64'h100), .COUNT_W(32)) dut (
        .clock(clock), .reset(reset), .PS(PS), .PCsel(PCsel), .IL(IL),
        .constant(constant), .A_bus(A_bus), .mem_data(mem_data),
        .PC(PC), .I(I), .IPC(IPC), .PC4(PC4), .fault(fault), .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.RESET_PC(64'h100), .COUNT_W(2)) dut_n (
        .clock(clock), .reset(reset), .PS(PS), .PCsel(PCsel), .IL(IL),
        .constant(constant), .A_bus(A_bus), .mem_data(mem_data),
        .PC(PC_n), .I(I_n), .IPC(IPC_n), .PC4(PC4_n), .fault(fault_n), .fetch_count(fetch_count_n)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  ps;
        logic        pcsel;
        logic        il;
        logic [63:0] cst;
        logic [63:0] a;
        logic [31:0] md;
        logic [63:0] e_pc;
        logic [31:0] e_i;
        logic [63:0] e_ipc;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] ps, input logic pcsel, input logic il,
                       input logic [63:0] cst, input logic [63:0] a, input logic [31:0] md,
                       input logic [63:0] e_pc, input logic [31:0] e_i, input logic [63:0] e_ipc,
                       input logic e_fault, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.ps = ps; v.pcsel = pcsel; v.il = il; v.cst = cst; v.a = a; v.md = md;
        v.e_pc = e_pc; v.e_i = e_i; v.e_ipc = e_ipc; v.e_fault = e_fault; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check64(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] ps, input logic pcsel, input logic il,
                         input logic [63:0] cst, input logic [63:0] a, input logic [31:0] md);
        reset = rst; PS = ps; PCsel = pcsel; IL = il; constant = cst; A_bus = a; mem_data = md;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; PS = 2'b00; PCsel = 1'b0; IL = 1'b0;
        constant = 64'h0; A_bus = 64'h0; mem_data = 32'h0;

        // reset, then three sequential fetches
        add(1, 2'b00, 0, 0, 64'h0, 64'h0, 32'h0,        64'h100, 32'h0,        64'h100, 0, 0);
        add(0, 2'b01, 0, 1, 64'h0, 64'h0, 32'hAAAA0001, 64'h104, 32'hAAAA0001, 64'h100, 0, 1);
        add(0, 2'b01, 0, 1, 64'h0, 64'h0, 32'hAAAA0002, 64'h108, 32'hAAAA0002, 64'h104, 0, 2);
        add(0, 2'b01, 0, 1, 64'h0, 64'h0, 32'hAAAA0003, 64'h10C, 32'hAAAA0003, 64'h108, 0, 3);
        // five idle cycles hold everything
        for (int k = 0; k < 5; k++)
            add(0, 2'b00, 0, 0, 64'h0, 64'h0, 32'hDEADBEEF, 64'h10C, 32'hAAAA0003, 64'h108, 0, 3);
        // jump to 200, fetch there, then PC-relative branches off IPC
        add(0, 2'b10, 0, 0, 64'h0, 64'h200, 32'h0,        64'h200, 32'hAAAA0003, 64'h108, 0, 3);
        add(0, 2'b01, 0, 1, 64'h0, 64'h0,   32'h11111111, 64'h204, 32'h11111111, 64'h200, 0, 4);
        add(0, 2'b11, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 32'h0, 64'h1F8, 32'h11111111, 64'h200, 0, 4);
        add(0, 2'b11, 0, 0, 64'h0, 64'h3,   32'h0,        64'h20C, 32'h11111111, 64'h200, 0, 4);
        // misaligned register jump sets a sticky fault
        add(0, 2'b10, 0, 0, 64'h0, 64'h403, 32'h0,        64'h400, 32'h11111111, 64'h200, 1, 4);
        add(0, 2'b10, 0, 0, 64'h0, 64'h500, 32'h0,        64'h500, 32'h11111111, 64'h200, 1, 4);
        add(1, 2'b00, 0, 0, 64'h0, 64'h0,   32'h0,        64'h100, 32'h0,        64'h100, 0, 0);
        // wrap-around at the top of the address space
        add(0, 2'b10, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'h100, 0, 0);
        add(0, 2'b01, 0, 0, 64'h0, 64'h0,   32'h0,        64'h0,   32'h0,        64'h100, 0, 0);
        // load and branch together: branch uses old IPC, IPC takes old PC
        add(0, 2'b11, 1, 1, 64'h1, 64'h0,   32'h22222222, 64'h104, 32'h22222222, 64'h0,   0, 1);
        // reset beats a simultaneous load and branch
        add(1, 2'b11, 1, 1, 64'h1, 64'h0,   32'h33333333, 64'h100, 32'h0,        64'h100, 0, 0);

        foreach (vecs[idx]) begin
            drive(vecs[idx].rst, vecs[idx].ps, vecs[idx].pcsel, vecs[idx].il,
                  vecs[idx].cst, vecs[idx].a, vecs[idx].md);
            check64("pc",    idx, PC, vecs[idx].e_pc);
            check64("i",     idx, 64'(I), 64'(vecs[idx].e_i));
            check64("ipc",   idx, IPC, vecs[idx].e_ipc);
            check64("pc4",   idx, PC4, vecs[idx].e_ipc + 64'd4);
            check64("fault", idx, 64'(fault), 64'(vecs[idx].e_fault));
            check64("count", idx, 64'(fetch_count), 64'(vecs[idx].e_cnt));
        end

        // narrow counter saturates at all-ones while the wide one keeps counting
        for (int k = 1; k <= 5; k++) begin
            drive(0, 2'b01, 0, 1, 64'h0, 64'h0, 32'(k));
            check64("count_wide", 100 + k, 64'(fetch_count), 64'(k));
            check64("count_sat",  100 + k, 64'(fetch_count_n), (k < 3) ? 64'(k) : 64'd3);
        end
        check64("pc_after_fetches", 106, PC, 64'h114);
        check64("i_after_fetches",  106, 64'(I), 64'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
